// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and memory bus bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
  parameter int N_REQ  = 3,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        req_we;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_wdata;
  logic [N_REQ-1:0]        gnt;
  logic [N_REQ-1:0]        rvalid;
  logic [DATA_W-1:0]       rdata;
  logic                    mem_en;
  logic                    mem_we;
  logic [ADDR_W-1:0]       mem_addr;
  logic [DATA_W-1:0]       mem_wdata;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    busy;

  // Arbiter side
  modport slave (
    input  req, req_we, req_addr, req_wdata, mem_rdata,
    output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Requesters plus memory side
  modport master (
    output req, req_we, req_addr, req_wdata, mem_rdata,
    input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one fixed-latency memory port
module mem_port_arbiter #(
  parameter int N_REQ   = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic               clk,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_rr_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_REQ-1:0]   r_win_oh;
  logic [N_REQ-1:0]   r_gnt;
  logic [N_REQ-1:0]   r_rvalid;
  logic [DATA_W-1:0]  r_rdata;
  logic               r_mem_en;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic               r_busy;

  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W-1:0]   w_next_ptr;
  logic [N_REQ-1:0]   w_win_oh;

  // Round-robin search: first set req bit starting at rr_ptr, wrapping modulo N_REQ
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      int k;
      k = int'(r_rr_ptr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!w_found && bus.req[k]) begin
        w_found = 1'b1;
        w_win   = PTR_W'(k);
      end
    end
    w_next_ptr = (w_win == PTR_W'(N_REQ - 1)) ? '0 : w_win + 1'b1;
    w_win_oh   = N_REQ'(1) << w_win;
  end

  // Transaction FSM; all outputs are registered so they change only on clock edges
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_cnt       <= '0;
      r_win_oh    <= '0;
      r_gnt       <= '0;
      r_rvalid    <= '0;
      r_rdata     <= '0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, RESP: begin
          r_rvalid <= '0;
          if (w_found) begin
            r_win_oh    <= w_win_oh;
            r_gnt       <= w_win_oh;
            r_mem_en    <= 1'b1;
            r_mem_we    <= bus.req_we[w_win];
            r_mem_addr  <= bus.req_addr[int'(w_win)*ADDR_W +: ADDR_W];
            r_mem_wdata <= bus.req_wdata[int'(w_win)*DATA_W +: DATA_W];
            r_rr_ptr    <= w_next_ptr;
            r_busy      <= 1'b1;
            r_state     <= ISSUE;
          end else begin
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        ISSUE: begin
          r_gnt    <= '0;
          r_mem_en <= 1'b0;
          r_cnt    <= CNT_W'(MEM_LAT - 1);
          r_state  <= WAIT;
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_rdata  <= r_mem_we ? '0 : bus.mem_rdata;
            r_rvalid <= r_win_oh;
            r_state  <= RESP;
          end else begin
            r_cnt    <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.rvalid    = r_rvalid;
  assign bus.rdata     = r_rdata;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.N_REQ(3), .ADDR_W(32), .DATA_W(32)) mif ();
  mem_port_arbiter_if #(.N_REQ(3), .ADDR_W(32), .DATA_W(32)) mif1 ();

  mem_port_arbiter #(.N_REQ(3), .ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  mem_port_arbiter #(.N_REQ(3), .ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_lat1 (
    .clk   (clk),
    .reset (reset),
    .bus   (mif1)
  );

  // Memory model for the MEM_LAT=2 instance: 0x40 reads as 0xDEADBEEF, other words from storage
  logic [31:0] mem [0:63];
  logic [31:0] pipe0, pipe1;
  always @(posedge clk) begin
    if (mif.mem_en && mif.mem_we) mem[mif.mem_addr[7:2]] <= mif.mem_wdata;
    if (mif.mem_en && !mif.mem_we)
      pipe0 <= (mif.mem_addr == 32'h40) ? 32'hDEADBEEF : mem[mif.mem_addr[7:2]];
    else
      pipe0 <= 32'hBAD0BAD0;
    pipe1 <= pipe0;
  end
  assign mif.mem_rdata  = pipe1;
  assign mif1.mem_rdata = 32'hCAFE0001;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    mif.req = '0; mif.req_we = '0; mif.req_addr = '0; mif.req_wdata = '0;
    mif1.req = '0; mif1.req_we = '0; mif1.req_addr = '0; mif1.req_wdata = '0;
    step();
    step();
    checks++;
    if (mif.gnt !== 3'b0 || mif.rvalid !== 3'b0 || mif.mem_en !== 1'b0 || mif.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: gnt=%b rvalid=%b mem_en=%b busy=%b, want all 0",
               mif.gnt, mif.rvalid, mif.mem_en, mif.busy);
    end
    checks++;
    if (mif.rdata !== 32'h0 || mif.mem_addr !== 32'h0 || mif.mem_we !== 1'b0 || mif.mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h mem_addr=%h mem_we=%b mem_wdata=%h, want 0",
               mif.rdata, mif.mem_addr, mif.mem_we, mif.mem_wdata);
    end
    reset = 1'b1;
  endtask

  task automatic test_single_read();
    mif.req = 3'b010; mif.req_we = 3'b000; mif.req_addr[32 +: 32] = 32'h40;
    step();
    checks++;
    if (mif.gnt !== 3'b010 || mif.mem_en !== 1'b1 || mif.mem_we !== 1'b0 || mif.mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL read_issue: gnt=%b mem_en=%b mem_we=%b mem_addr=%h, want 010 1 0 00000040",
               mif.gnt, mif.mem_en, mif.mem_we, mif.mem_addr);
    end
    mif.req = 3'b000;
    step();
    checks++;
    if (mif.gnt !== 3'b0 || mif.mem_en !== 1'b0 || mif.busy !== 1'b1) begin
      errors++;
      $display("FAIL read_wait: gnt=%b mem_en=%b busy=%b, want 000 0 1", mif.gnt, mif.mem_en, mif.busy);
    end
    step();
    step();
    checks++;
    if (mif.rvalid !== 3'b010 || mif.rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_resp: rvalid=%b rdata=%h, want 010 deadbeef", mif.rvalid, mif.rdata);
    end
    step();
    checks++;
    if (mif.rvalid !== 3'b0 || mif.busy !== 1'b0 || mif.rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL read_idle: rvalid=%b busy=%b rdata=%h, want 000 0 deadbeef",
               mif.rvalid, mif.busy, mif.rdata);
    end
  endtask

  task automatic test_write();
    mif.req = 3'b001; mif.req_we = 3'b001;
    mif.req_addr[0 +: 32] = 32'h10; mif.req_wdata[0 +: 32] = 32'h12345678;
    step();
    checks++;
    if (mif.gnt !== 3'b001 || mif.mem_en !== 1'b1 || mif.mem_we !== 1'b1 ||
        mif.mem_addr !== 32'h10 || mif.mem_wdata !== 32'h12345678) begin
      errors++;
      $display("FAIL write_issue: gnt=%b en=%b we=%b addr=%h wdata=%h, want 001 1 1 00000010 12345678",
               mif.gnt, mif.mem_en, mif.mem_we, mif.mem_addr, mif.mem_wdata);
    end
    mif.req = 3'b000; mif.req_we = 3'b000;
    step();
    step();
    step();
    checks++;
    if (mif.rvalid !== 3'b001 || mif.rdata !== 32'h0) begin
      errors++;
      $display("FAIL write_resp: rvalid=%b rdata=%h, want 001 00000000", mif.rvalid, mif.rdata);
    end
    // Read the written word back through requester 2
    step();
    mif.req = 3'b100; mif.req_addr[64 +: 32] = 32'h10;
    step();
    checks++;
    if (mif.gnt !== 3'b100) begin
      errors++;
      $display("FAIL readback_gnt: gnt=%b, want 100", mif.gnt);
    end
    mif.req = 3'b000;
    step();
    step();
    step();
    checks++;
    if (mif.rvalid !== 3'b100 || mif.rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL readback_resp: rvalid=%b rdata=%h, want 100 12345678", mif.rvalid, mif.rdata);
    end
    step();
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_gnt;
    do_reset();
    mif.req = 3'b111; mif.req_we = 3'b000;
    mif.req_addr = {32'h48, 32'h44, 32'h40};
    for (int i = 1; i <= 24; i++) begin
      step();
      exp_gnt = (i % 4 == 1) ? (3'b001 << ((i / 4) % 3)) : 3'b000;
      checks++;
      if (mif.gnt !== exp_gnt || mif.busy !== 1'b1 || (mif.gnt & mif.rvalid) !== 3'b0) begin
        errors++;
        $display("FAIL rr_cycle%0d: gnt=%b busy=%b rvalid=%b, want gnt=%b busy=1 no overlap",
                 i, mif.gnt, mif.busy, mif.rvalid, exp_gnt);
      end
    end
    mif.req = 3'b000;
    for (int i = 0; i < 6; i++) step();
  endtask

  task automatic test_resp_arbitration();
    do_reset();
    mif.req = 3'b100; mif.req_we = 3'b000; mif.req_addr = {32'h40, 32'h44, 32'h40};
    step();
    checks++;
    if (mif.gnt !== 3'b100) begin
      errors++;
      $display("FAIL resp_first_gnt: gnt=%b, want 100", mif.gnt);
    end
    mif.req = 3'b000;
    step();
    step();
    step();
    checks++;
    if (mif.rvalid !== 3'b100) begin
      errors++;
      $display("FAIL resp_first_rvalid: rvalid=%b, want 100", mif.rvalid);
    end
    mif.req = 3'b101;
    step();
    checks++;
    if (mif.gnt !== 3'b001 || mif.mem_en !== 1'b1 || mif.busy !== 1'b1 || mif.mem_addr !== 32'h40) begin
      errors++;
      $display("FAIL resp_rearb: gnt=%b mem_en=%b busy=%b addr=%h, want 001 1 1 00000040",
               mif.gnt, mif.mem_en, mif.busy, mif.mem_addr);
    end
    mif.req = 3'b000;
    step();
    step();
    step();
    checks++;
    if (mif.rvalid !== 3'b001 || mif.rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL resp_second: rvalid=%b rdata=%h, want 001 deadbeef", mif.rvalid, mif.rdata);
    end
    step();
  endtask

  task automatic test_reset_mid_wait();
    mif.req = 3'b010; mif.req_we = 3'b000; mif.req_addr[32 +: 32] = 32'h40;
    step();
    mif.req = 3'b000;
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (mif.gnt !== 3'b0 || mif.rvalid !== 3'b0 || mif.mem_en !== 1'b0 || mif.busy !== 1'b0 ||
        mif.rdata !== 32'h0 || mif.mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: gnt=%b rvalid=%b en=%b busy=%b rdata=%h addr=%h, want all 0",
               mif.gnt, mif.rvalid, mif.mem_en, mif.busy, mif.rdata, mif.mem_addr);
    end
    step();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (mif.rvalid !== 3'b0 || mif.busy !== 1'b0) begin
        errors++;
        $display("FAIL abandoned_cycle%0d: rvalid=%b busy=%b, want 000 0", i, mif.rvalid, mif.busy);
      end
    end
    mif.req = 3'b010;
    step();
    checks++;
    if (mif.gnt !== 3'b010) begin
      errors++;
      $display("FAIL post_reset_gnt: gnt=%b, want 010", mif.gnt);
    end
    mif.req = 3'b000;
    step();
    step();
    step();
    checks++;
    if (mif.rvalid !== 3'b010 || mif.rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL post_reset_resp: rvalid=%b rdata=%h, want 010 deadbeef", mif.rvalid, mif.rdata);
    end
    step();
  endtask

  task automatic test_lat1();
    mif1.req = 3'b010; mif1.req_we = 3'b000; mif1.req_addr[32 +: 32] = 32'h80;
    step();
    checks++;
    if (mif1.gnt !== 3'b010 || mif1.mem_en !== 1'b1 || mif1.mem_addr !== 32'h80) begin
      errors++;
      $display("FAIL lat1_issue: gnt=%b en=%b addr=%h, want 010 1 00000080",
               mif1.gnt, mif1.mem_en, mif1.mem_addr);
    end
    mif1.req = 3'b000;
    step();
    checks++;
    if (mif1.rvalid !== 3'b000 || mif1.busy !== 1'b1) begin
      errors++;
      $display("FAIL lat1_wait: rvalid=%b busy=%b, want 000 1", mif1.rvalid, mif1.busy);
    end
    step();
    checks++;
    if (mif1.rvalid !== 3'b010 || mif1.rdata !== 32'hCAFE0001) begin
      errors++;
      $display("FAIL lat1_resp: rvalid=%b rdata=%h, want 010 cafe0001", mif1.rvalid, mif1.rdata);
    end
    step();
    checks++;
    if (mif1.rvalid !== 3'b000 || mif1.busy !== 1'b0) begin
      errors++;
      $display("FAIL lat1_idle: rvalid=%b busy=%b, want 000 0", mif1.rvalid, mif1.busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write();
    test_round_robin();
    test_resp_arbitration();
    test_reset_mid_wait();
    test_lat1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency memory among N_REQ requesters: instruction fetch, core load/store, and debug loader/DMA.
- Sits between the single-cycle core's memory interfaces and the unified memory.
- Arbitrates round-robin and keeps one transaction outstanding at a time.
- Returns read data or write acks on a per-requester valid pulse; the core stalls on missing rvalid.

Parameters:
N_REQ, 3, number of requesters (index 0 = fetch, 1 = data, 2 = debug)
ADDR_W, 32, address width
DATA_W, 32, data width
MEM_LAT, 2, cycles from mem_en to valid mem_rdata (>=1)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
req  input  N_REQ  per-requester request level
req_we  input  N_REQ  per-requester write enable
req_addr  input  N_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  input  N_REQ*DATA_W  packed write data
gnt  output  N_REQ  one-hot, 1-cycle pulse: request accepted
rvalid  output  N_REQ  one-hot, 1-cycle pulse: read data or write ack
rdata  output  DATA_W  read data, valid when any rvalid bit is set
mem_en  output  1  memory access strobe
mem_we  output  1  memory write
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, valid MEM_LAT cycles after mem_en
busy  output  1  high in every state except IDLE

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr 0, latency counter 0. Reset is asynchronous; mid-transaction reset abandons the access with no rvalid.
- States:
  - IDLE
  - ISSUE (1 cycle)
  - WAIT (MEM_LAT cycles)
  - RESP (1 cycle)
- Arbitration happens in IDLE and in RESP when any req bit is 1 at the clock edge.
  - Winner = first set req bit scanning from rr_ptr upward, modulo N_REQ.
  - The winner's we/addr/wdata are captured into registers; next state is ISSUE.
  - rr_ptr <= (winner+1) mod N_REQ.
  - No req: RESP -> IDLE; IDLE holds.
- ISSUE: mem_en=1 and mem_we/mem_addr/mem_wdata come from the captured registers. gnt[winner]=1 for this cycle only. Counter loads MEM_LAT-1; next state is WAIT.
- WAIT: mem_en=0. Counter decrements each cycle.
  - When counter==0 and the transaction is a read, mem_rdata is registered into rdata.
  - For a write, rdata <= 0.
  - Next state is RESP.
- RESP: rvalid[winner]=1 for one cycle; rdata holds the captured value. rdata holds its value until the next capture.
- Latency: req sampled at edge k -> gnt and mem_en in cycle k+1 -> rvalid in cycle k+2+MEM_LAT.
- Back-to-back throughput: one transaction per MEM_LAT+2 cycles.
- Requester rules:
  - Hold req/we/addr/wdata stable until gnt.
  - Deassert req in the gnt cycle; a req still high in RESP is a new request.
  - Dropping req before being sampled cancels it with no side effect.
- Simultaneous requests: exactly one winner. Bound for a continuously requesting master: at most N_REQ-1 other transactions before its grant.
- mem_* address/data outputs hold their last values outside ISSUE; only mem_en qualifies them.
- gnt and rvalid are never asserted together in the same cycle.

Test Plan:
- Reset, then single read by requester 1 at addr 0x40, mem returns 0xDEADBEEF: gnt=3'b010 at cycle 1; rvalid=3'b010 with rdata=0xDEADBEEF at cycle 4 (MEM_LAT=2).
- Write by requester 0, addr 0x10, wdata 0x12345678: ISSUE shows mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0x12345678; rvalid=3'b001 with rdata=0 at cycle 4.
- All three req held continuously from reset: grant order 0,1,2,0,1,2; gnt pulses 4 cycles apart; busy never drops.
- Requester 2 alone, then requesters 0 and 2 both request in RESP: rr_ptr=0, so requester 0 wins; ISSUE follows RESP with no IDLE cycle.
- Reset (reset=0) asserted during WAIT: outputs 0 immediately with no rvalid; after release, a new read by requester 1 completes normally.
- MEM_LAT=1 build: read completes with rvalid 3 cycles after req is sampled.
